// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the parametrised register file and its wipe sequencer.
package reg_file_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int ZERO_ADDR      = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;
endpackage

// File: rtl/reg_file_clear_fsm.sv
// Wipe sequencer: walks every array entry once, one per cycle, after a CLEAR request.
// Latency: busy rises the cycle after clear; werr is a one-cycle pulse after a refused write.
// Backpressure: none; writes arriving while busy are dropped and flagged on werr.
module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  write,
    output logic                  busy,
    output logic                  werr,
    output logic                  clr_en,
    output logic [ADDR_WIDTH-1:0] clr_addr
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    sweep_state_t          state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            werr  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            werr  <= write && busy;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                end
            end
            SWEEP: begin
                // Leaving on the last entry keeps the counter wrap from starting a second pass.
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state == SWEEP);
    assign clr_en   = busy;
    assign clr_addr = cnt;
endmodule

// File: rtl/reg_file_param.sv
// Register file: two registered read ports, one write port, optional bypass and zero register.
// Latency: 1 cycle on reads. Writes are refused while a wipe is running (BUSY), flagged on WERR.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2,
    input  logic                  CLEAR,
    output logic                  BUSY,
    output logic                  WERR
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZA = ADDR_WIDTH'(ZERO_ADDR);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  clr_en;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_acc;
    logic [DATA_WIDTH-1:0] rd1, rd2;

    reg_file_clear_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_fsm (
        .clk      (CLK),
        .reset    (RESET),
        .clear    (CLEAR),
        .write    (WRITE),
        .busy     (BUSY),
        .werr     (WERR),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    // Writes to the hardwired zero register vanish without raising WERR.
    assign wr_acc = WRITE && !BUSY && !((ZERO_REG != 0) && (INADDRESS == ZA));

    function automatic logic [DATA_WIDTH-1:0] read_mux(
        input logic [ADDR_WIDTH-1:0] a,
        input logic                  acc,
        input logic [ADDR_WIDTH-1:0] wa,
        input logic [DATA_WIDTH-1:0] wd,
        input logic [DATA_WIDTH-1:0] stored
    );
        if ((ZERO_REG != 0) && (a == ZA)) return '0;
        if ((BYPASS != 0) && acc && (a == wa)) return wd;
        return stored;
    endfunction

    always_comb begin
        rd1 = read_mux(OUT1ADDRESS, wr_acc, INADDRESS, IN, regs[OUT1ADDRESS]);
        rd2 = read_mux(OUT2ADDRESS, wr_acc, INADDRESS, IN, regs[OUT2ADDRESS]);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            OUT1 <= '0;
            OUT2 <= '0;
        end else begin
            // Sweep and accepted writes are mutually exclusive: writes only land while idle.
            if (clr_en) regs[clr_addr] <= '0;
            if (wr_acc) regs[INADDRESS] <= IN;
            OUT1 <= rd1;
            OUT2 <= rd2;
        end
    end
endmodule

// File: tb/tb_reg_file_param.sv
// Bench: bypass/no-zero and no-bypass/zero-reg instances share stimulus; a behavioural model predicts both.
module tb_reg_file_param;
    logic       clk = 1'b0;
    logic       rst, wr, clr;
    logic [7:0] din;
    logic [2:0] ia, a1, a2;
    logic [7:0] o1_a, o2_a, o1_b, o2_b;
    logic       busy_a, werr_a, busy_b, werr_b;

    int total = 0;
    int passed = 0;

    logic [7:0] mm [2][8];
    logic [7:0] e1 [2];
    logic [7:0] e2 [2];
    int sweep_left = 0;
    int sweep_idx = 0;
    logic e_busy = 1'b0;
    logic e_werr = 1'b0;

    always #5 clk = ~clk;

    reg_file_param dut_a (
        .CLK(clk), .RESET(rst), .IN(din), .INADDRESS(ia), .WRITE(wr),
        .OUT1ADDRESS(a1), .OUT2ADDRESS(a2), .OUT1(o1_a), .OUT2(o2_a),
        .CLEAR(clr), .BUSY(busy_a), .WERR(werr_a)
    );

    reg_file_param #(.BYPASS(0), .ZERO_REG(1)) dut_b (
        .CLK(clk), .RESET(rst), .IN(din), .INADDRESS(ia), .WRITE(wr),
        .OUT1ADDRESS(a1), .OUT2ADDRESS(a2), .OUT1(o1_b), .OUT2(o2_b),
        .CLEAR(clr), .BUSY(busy_b), .WERR(werr_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %02h want %02h at %0t", tag, obs, exp, $time);
    endtask

    // Instance 0: bypass on, no zero register. Instance 1: bypass off, zero register.
    task automatic model_step();
        logic busy_now;
        logic acc;
        logic zr, bp;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j < 8; j++) mm[k][j] = 8'h00;
                e1[k] = 8'h00;
                e2[k] = 8'h00;
            end
            sweep_left = 0;
            sweep_idx  = 0;
            e_werr     = 1'b0;
        end else begin
            busy_now = (sweep_left > 0);
            for (int k = 0; k < 2; k++) begin
                zr  = (k == 1);
                bp  = (k == 0);
                acc = wr && !busy_now && !(zr && ia == 3'd0);
                e1[k] = (zr && a1 == 3'd0) ? 8'h00 : (bp && acc && ia == a1) ? din : mm[k][a1];
                e2[k] = (zr && a2 == 3'd0) ? 8'h00 : (bp && acc && ia == a2) ? din : mm[k][a2];
                if (acc) mm[k][ia] = din;
                if (busy_now) mm[k][sweep_idx] = 8'h00;
            end
            e_werr = wr && busy_now;
            if (busy_now) begin
                sweep_idx++;
                sweep_left--;
            end else if (clr) begin
                sweep_left = 8;
                sweep_idx  = 0;
            end
        end
        e_busy = (sweep_left > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("out1_bypass", o1_a, e1[0]);
        chk("out2_bypass", o2_a, e2[0]);
        chk("out1_zreg", o1_b, e1[1]);
        chk("out2_zreg", o2_b, e2[1]);
        chk("busy_a", {7'd0, busy_a}, {7'd0, e_busy});
        chk("busy_b", {7'd0, busy_b}, {7'd0, e_busy});
        chk("werr_a", {7'd0, werr_a}, {7'd0, e_werr});
        chk("werr_b", {7'd0, werr_b}, {7'd0, e_werr});
    endtask

    task automatic quiet();
        rst = 1'b0; wr = 1'b0; clr = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        wr = 1'b1; ia = a; din = d;
        tick();
        wr = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        rst = 1'b1; wr = 1'b0; clr = 1'b0; din = 8'h00; ia = 3'd0; a1 = 3'd0; a2 = 3'd0;
        tick();
        tick();
        quiet();

        // Reset wipes a written entry
        do_write(3'd3, 8'hAA);
        rst = 1'b1; tick(); rst = 1'b0;
        a1 = 3'd3; a2 = 3'd3; tick();

        // Dual-port read latency, then both ports on one register
        do_write(3'd2, 8'h5C);
        do_write(3'd6, 8'h13);
        a1 = 3'd2; a2 = 3'd6; tick();
        a1 = 3'd6; tick();

        // Same-cycle write/read: forwarded only in the bypass build
        do_write(3'd4, 8'h11);
        a1 = 3'd4;
        do_write(3'd4, 8'h77);
        tick();

        // Register 0 write and same-cycle read
        a1 = 3'd0; a2 = 3'd0;
        do_write(3'd0, 8'hFF);
        tick();

        // Fill, sweep, repeat CLEAR mid-sweep, refused write mid-sweep
        for (int i = 0; i < 8; i++) do_write(i[2:0], 8'(i + 1));
        clr = 1'b1; tick(); clr = 1'b0;
        a1 = 3'd7; a2 = 3'd0;
        busy_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            clr = (k == 2);
            if (k == 3) begin wr = 1'b1; ia = 3'd5; din = 8'h42; end
            if (busy_a) busy_cnt++;
            tick();
            wr = 1'b0; clr = 1'b0;
        end
        total++;
        assert (busy_cnt == 8) passed++;
        else $error("FAIL busy_len: got %0d cycles want 8", busy_cnt);
        a1 = 3'd5; a2 = 3'd7; tick();

        // Reset aborts a sweep
        for (int i = 0; i < 8; i++) do_write(i[2:0], 8'hA0 + 8'(i));
        clr = 1'b1; tick(); clr = 1'b0;
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a1 = i[2:0]; a2 = 3'(7 - i); tick();
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            wr  = $urandom_range(0, 1) == 1;
            clr = ($urandom_range(0, 24) == 0);
            din = 8'($urandom);
            ia  = 3'($urandom);
            a1  = 3'($urandom);
            a2  = ($urandom_range(0, 3) == 0) ? ia : 3'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
